mem_port_arbiter: RTL

- Shares the single-port unified memory between the instruction-fetch requester (driven during the control FSM's fetch phase) and the data requester (load/store phases).
- Sequences each access (issue, wait for the fixed memory latency, respond) and arbitrates simultaneous requests round-robin.
- Reports busy/state back to the control FSM, which must hold its phase until the requester's done pulse.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory sharer between instruction fetch and data load/store requesters.
// Sequences IDLE -> ISSUE -> (WAIT) -> RESP with round-robin arbitration on simultaneous requests.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic arb_en;
    logic cand_f;
    logic cand_d;
    logic winner;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        // The requester in its done cycle still holds req high; mask it so it cannot win again.
        arb_en = ((state_q == S_IDLE) || (state_q == S_RESP)) && !halt;
        cand_f = if_req && !((state_q == S_RESP) && (owner_q == GNT_F));
        cand_d = d_req  && !((state_q == S_RESP) && (owner_q == GNT_D));
        winner = (cand_f && cand_d) ? ~last_q : cand_d;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (arb_en && (cand_f || cand_d)) begin
                    state_d = S_ISSUE;
                    last_d  = winner;
                    owner_d = winner;
                    if (winner == GNT_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(MEM_LATENCY);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (owner_q == GNT_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= GNT_F;
            owner_q    <= GNT_F;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Memory strobes are decoded from state only, so nothing combinational reaches them from req.
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign if_done  = (state_q == S_RESP) && (owner_q == GNT_F);
    assign d_done   = (state_q == S_RESP) && (owner_q == GNT_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q != S_IDLE);
    assign state    = state_q;

endmodule
